// File: rtl/core_pkg.sv
// Shared definitions for the core's memory-port controller.
// Contents:
//   - Default bus widths and timeout used as parameter defaults.
//   - mem_op_e : command encodings from the core state machine.
//   - mem_state_t : controller FSM states, also visible on the debug port.
package core_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_ID_W    = 16;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'b00,
    MEM_OP_READ  = 2'b01,
    MEM_OP_WRITE = 2'b10,
    MEM_OP_RSVD  = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_R = 2'b10
  } mem_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Clearable saturating cycle counter with a terminal-count strobe.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : restart the count at zero (wins over inc_i)
//   inc_i        : count this cycle
//   tc_o         : this increment brings the count to LIMIT
// Only instantiated when MEM_PORT_TIMEOUT_EN is defined.
module mem_timeout_ctr #(
  parameter int CNT_W = 16,
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [CNT_W:0] LIMIT_EXT = (CNT_W + 1)'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_max;

  assign at_max = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires in the cycle whose increment reaches LIMIT, so a limit of N
  // aborts after N cycles spent waiting.
  assign tc_o = inc_i && !clr_i && (({1'b0, cnt_q} + 1'b1) == LIMIT_EXT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory-port controller: takes one load/store at a time from the core
// state machine and runs it over a request/grant/response handshake.
// Ports:
//   Clock, Reset            : clock, synchronous active-high reset
//   core_id                 : static tag placed on mem_id
//   cmd_valid/op/addr/wdata : command from the state machine
//   busy                    : stall, high from the acceptance cycle to completion
//   done, rdata_valid, err  : one-cycle result pulses; rdata holds last load
//   mem_req/we/addr/wdata/id: registered request, held until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata : memory responses
//   dbg_state               : current FSM state
// Handshake: a request is transferred in the cycle mem_req and mem_gnt are
// both high; read data is transferred on any cycle mem_rvalid is high at or
// after the grant cycle. mem_rvalid outside that window is ignored.
// Build option: MEM_PORT_TIMEOUT_EN aborts an access after TIMEOUT cycles.
module mem_port_ctrl
  import core_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ID_W    = DEF_ID_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ID_W-1:0]   core_id,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              busy,
  output logic              done,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ID_W-1:0]   mem_id,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  mem_state_t        state_q;
  logic              done_q, rdata_valid_q, err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [ID_W-1:0]   mem_id_q;
  logic              accept;
  logic              timeout_hit;

  assign accept = cmd_valid && (state_q == IDLE) &&
                  ((cmd_op == MEM_OP_READ) || (cmd_op == MEM_OP_WRITE));
  // Combinational so the state machine stalls in the acceptance cycle.
  assign busy = accept || (state_q != IDLE);

`ifdef MEM_PORT_TIMEOUT_EN
  mem_timeout_ctr #(
    .CNT_W (16),
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk_i (Clock),
    .rst_i (Reset),
    .clr_i (accept),
    .inc_i (state_q != IDLE),
    .tc_o  (timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= IDLE;
      done_q        <= 1'b0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_id_q      <= '0;
    end else begin
      done_q        <= 1'b0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (accept) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= (cmd_op == MEM_OP_WRITE);
              mem_addr_q  <= cmd_addr;
              mem_wdata_q <= cmd_wdata;
              mem_id_q    <= core_id;
              state_q     <= REQ;
            end else if (cmd_op == MEM_OP_RSVD) begin
              err_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (cmd_valid) err_q <= 1'b1;
          // Completion is checked first so it wins over a same-cycle timeout.
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else if (mem_rvalid) begin
              rdata_q       <= mem_rdata;
              rdata_valid_q <= 1'b1;
              done_q        <= 1'b1;
              state_q       <= IDLE;
            end else begin
              state_q <= WAIT_R;
            end
          end else if (timeout_hit) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= IDLE;
          end
        end
        WAIT_R: begin
          if (cmd_valid) err_q <= 1'b1;
          if (mem_rvalid) begin
            rdata_q       <= mem_rdata;
            rdata_valid_q <= 1'b1;
            done_q        <= 1'b1;
            state_q       <= IDLE;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done        = done_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_id      = mem_id_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl. The bench plays the shared memory
// (an associative array) with chosen grant/data delays and predicts every
// pulse from the transaction timing: accept in cycle 0, request visible in
// cycle 1, grant in cycle 1+g, read data in cycle 1+g+r, result pulses in
// cycle 2+g+r (r = 0 for writes).
module tb_mem_port_ctrl;
  import core_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] core_id = 16'hC0DE;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        busy, done, rdata_valid, err;
  logic [15:0] rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_id;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mem_model [logic [15:0]];
  logic [15:0] last_rd = '0;

  mem_port_ctrl #(
    .DATA_W (16), .ADDR_W (16), .ID_W (16), .TIMEOUT (8)
  ) dut (
    .Clock (Clock), .Reset (Reset), .core_id (core_id),
    .cmd_valid (cmd_valid), .cmd_op (cmd_op), .cmd_addr (cmd_addr),
    .cmd_wdata (cmd_wdata), .busy (busy), .done (done),
    .rdata_valid (rdata_valid), .rdata (rdata), .err (err),
    .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_id (mem_id), .mem_gnt (mem_gnt),
    .mem_rvalid (mem_rvalid), .mem_rdata (mem_rdata), .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One full access. Entered in the caller's cycle 0 and returns in the done
  // cycle, so a following call is issued back-to-back. extra_at > 0 injects
  // a second (dropped) command in that cycle of the access.
  task automatic run_txn(input logic [1:0] op, input logic [15:0] addr,
                         input logic [15:0] wdata, input int g, input int r_in,
                         input int extra_at);
    logic        is_rd;
    logic [15:0] rd_val;
    int          r, last;
    is_rd = (op == MEM_OP_READ);
    r = is_rd ? r_in : 0;
    last = 2 + g + r;
    rd_val = '0;
    if (is_rd) begin
      if (!mem_model.exists(addr)) mem_model[addr] = 16'($urandom);
      rd_val = mem_model[addr];
      exp_q.push_back(rd_val);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
    #1;
    check_eq("busy_accept", {31'd0, busy}, 32'd1);
    for (int c = 1; c <= last; c++) begin
      tick();
      cmd_valid = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'($urandom);
      #1;
      check_eq("err", {31'd0, err}, {31'd0, (extra_at > 0) && (c == extra_at + 1)});
      if (c < last) begin
        check_eq("busy_wait", {31'd0, busy}, 32'd1);
        check_eq("done_early", {31'd0, done}, 32'd0);
        check_eq("rvalid_early", {31'd0, rdata_valid}, 32'd0);
        check_eq("mem_req", {31'd0, mem_req}, {31'd0, c <= 1 + g});
        if (c <= 1 + g) begin
          check_eq("mem_we", {31'd0, mem_we}, {31'd0, !is_rd});
          check_eq("mem_addr", {16'd0, mem_addr}, {16'd0, addr});
          check_eq("mem_id", {16'd0, mem_id}, {16'd0, core_id});
          if (!is_rd) check_eq("mem_wdata", {16'd0, mem_wdata}, {16'd0, wdata});
        end
        if (c == 1 + g) mem_gnt = 1'b1;
        if (is_rd && c == 1 + g + r) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd_val;
        end else if (is_rd && c < 1 + g && $urandom_range(0, 3) == 0) begin
          mem_rvalid = 1'b1;  // stray data before the grant is ignored
        end
        if (c == extra_at) begin
          cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_addr = 16'($urandom);
        end
      end else begin
        check_eq("done", {31'd0, done}, 32'd1);
        check_eq("rdata_valid", {31'd0, rdata_valid}, {31'd0, is_rd});
        check_eq("mem_req_end", {31'd0, mem_req}, 32'd0);
        check_eq("busy_end", {31'd0, busy}, 32'd0);
        if (is_rd) last_rd = exp_q.pop_front();
        else mem_model[addr] = wdata;
        check_eq("rdata", {16'd0, rdata}, {16'd0, last_rd});
      end
    end
  endtask

`ifdef MEM_PORT_TIMEOUT_EN
  // Access with no completion: err expected in cycle 9 for TIMEOUT=8.
  task automatic run_timeout(input logic [1:0] op, input logic give_gnt);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = 16'h0300; cmd_wdata = 16'h5555;
    for (int c = 1; c <= 9; c++) begin
      tick();
      cmd_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      #1;
      if (c < 9) begin
        check_eq("to_err_early", {31'd0, err}, 32'd0);
        check_eq("to_busy", {31'd0, busy}, 32'd1);
        check_eq("to_req", {31'd0, mem_req}, {31'd0, give_gnt ? (c == 1) : 1'b1});
        if (give_gnt && c == 1) mem_gnt = 1'b1;
      end else begin
        check_eq("to_err", {31'd0, err}, 32'd1);
        check_eq("to_done", {31'd0, done}, 32'd0);
        check_eq("to_rvalid", {31'd0, rdata_valid}, 32'd0);
        check_eq("to_req_end", {31'd0, mem_req}, 32'd0);
        check_eq("to_busy_end", {31'd0, busy}, 32'd0);
        check_eq("to_rdata", {16'd0, rdata}, {16'd0, last_rd});
      end
    end
    tick();
    check_eq("to_err_clear", {31'd0, err}, 32'd0);
  endtask
`endif

  initial begin
    int g, r, ex, gap;
    logic [1:0] op;
    // reset
    repeat (3) tick();
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_rdata", {16'd0, rdata}, 32'd0);
    check_eq("rst_pulses", {29'd0, done, rdata_valid, err}, 32'd0);
    check_eq("rst_mem_bus", {mem_addr, mem_wdata}, 32'd0);
    Reset = 1'b0;
    tick();

    // directed: zero-wait write, delayed read, same-cycle gnt+rvalid read
    run_txn(MEM_OP_WRITE, 16'h0040, 16'hBEEF, 0, 0, 0);
    tick();
    mem_model[16'h0100] = 16'h1234;
    run_txn(MEM_OP_READ, 16'h0100, 16'h0000, 3, 2, 0);
    tick();
    mem_model[16'h0080] = 16'h00FF;
    run_txn(MEM_OP_READ, 16'h0080, 16'h0000, 0, 0, 0);
    // back-to-back from the done cycle, with a dropped command mid-read
    run_txn(MEM_OP_READ, 16'h0040, 16'h0000, 2, 1, 2);
    tick();

    // reserved op in IDLE
    cmd_valid = 1'b1; cmd_op = MEM_OP_RSVD; #1;
    check_eq("rsvd_busy", {31'd0, busy}, 32'd0);
    tick(); cmd_valid = 1'b0; #1;
    check_eq("rsvd_err", {31'd0, err}, 32'd1);
    check_eq("rsvd_req", {31'd0, mem_req}, 32'd0);
    tick();
    check_eq("rsvd_err_clear", {31'd0, err}, 32'd0);

    // stray rvalid in IDLE
    mem_rvalid = 1'b1; mem_rdata = 16'hA5A5;
    tick(); mem_rvalid = 1'b0;
    check_eq("stray_rdata", {16'd0, rdata}, {16'd0, last_rd});
    check_eq("stray_pulses", {30'd0, done, rdata_valid}, 32'd0);

    // reset while waiting for read data
    cmd_valid = 1'b1; cmd_op = MEM_OP_READ; cmd_addr = 16'h0200;
    tick(); cmd_valid = 1'b0; mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0;
    check_eq("wait_r_state", {30'd0, dbg_state}, {30'd0, WAIT_R});
    Reset = 1'b1;
    tick();
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check_eq("mid_rst_rdata", {16'd0, rdata}, 32'd0);
    check_eq("mid_rst_done", {31'd0, done}, 32'd0);
    Reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
    tick(); mem_rvalid = 1'b0;
    check_eq("late_rvalid_rdata", {16'd0, rdata}, 32'd0);
    check_eq("late_rvalid_pulses", {30'd0, done, rdata_valid}, 32'd0);
    last_rd = '0;

`ifdef MEM_PORT_TIMEOUT_EN
    run_timeout(MEM_OP_WRITE, 1'b0);
    run_timeout(MEM_OP_READ, 1'b1);
    run_txn(MEM_OP_WRITE, 16'h0044, 16'h7777, 7, 0, 0);  // gnt at count 8
    tick();
`endif

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      op = ($urandom_range(0, 1) == 0) ? MEM_OP_READ : MEM_OP_WRITE;
      g = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      ex = 0;
      if ($urandom_range(0, 3) == 0) ex = $urandom_range(1, 1 + g + ((op == MEM_OP_READ) ? r : 0));
      if ($urandom_range(0, 7) == 0) core_id = 16'($urandom);
      run_txn(op, 16'($urandom_range(0, 7)), 16'($urandom), g, r, ex);
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) tick();
    end

    tick();
    check_eq("final_busy", {31'd0, busy}, 32'd0);
    check_eq("final_queue", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
- Parametrised memory-port controller for the core.
- Replaces the fire-and-forget `memcontrol`/address/data outputs with a registered request/grant/response handshake to shared memory.
- Accepts one load or store at a time from the core state machine and holds `busy` (stall) until the access completes.
- Tags each request with the core ID so the shared-memory arbiter can route responses in multi-core builds.

Parameters:
- DATA_W, 16, data bus width.
- ADDR_W, 16, address width.
- ID_W, 16, core ID width.
- TIMEOUT, 255, cycles allowed from request issue to completion before abort (1..2^16-1).

Ports:
- Clock  in  1  core clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- core_id  in  ID_W  static core identifier.
- cmd_valid  in  1  command strobe from the state machine.
- cmd_op  in  2  00 none, 01 read, 10 write, 11 reserved.
- cmd_addr  in  ADDR_W  access address.
- cmd_wdata  in  DATA_W  store data.
- busy  out  1  stall to the state machine.
- done  out  1  one-cycle completion pulse, read or write.
- rdata_valid  out  1  one-cycle pulse, rdata is valid.
- rdata  out  DATA_W  load data, held until the next load completes.
- err  out  1  one-cycle error pulse.
- mem_req  out  1  request to memory.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  DATA_W  request data.
- mem_id  out  ID_W  requester tag.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset and clock: synchronous active-high Reset, single clock Clock.
- Reset values: state IDLE; all outputs 0, including rdata. Reset mid-access aborts the access with no done/err pulse, and mem_req is 0 after that edge.
- FSM states: IDLE, REQ, WAIT_R. All memory-side outputs are registered.
- IDLE:
  - cmd_valid with op 01 or 10: latch addr/wdata/op/core_id and go to REQ. mem_req=1 from the next cycle.
  - op 00: ignored.
  - op 11: err pulse next cycle, stay IDLE.
- busy: combinational, = cmd accepted this cycle OR state != IDLE. It is high in the acceptance cycle, so the state machine stalls immediately.
- cmd_valid while state != IDLE: command dropped, err pulse next cycle, in-flight access unaffected.
- REQ:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_id are held stable until mem_gnt is sampled high.
  - Write with gnt: done pulse next cycle, go to IDLE, mem_req=0.
  - Read with gnt and no rvalid: go to WAIT_R, mem_req=0.
  - Read with gnt and rvalid in the same cycle: capture mem_rdata, rdata_valid + done next cycle, go to IDLE.
  - mem_rvalid without gnt: ignored.
- WAIT_R: on mem_rvalid, rdata <= mem_rdata, rdata_valid and done pulse next cycle, go to IDLE.
- mem_rvalid in IDLE (late or stray): ignored; rdata unchanged.
- Latency (zero-wait memory):
  - Accept at cycle 0, mem_req cycle 1, gnt cycle 1.
  - Write done at cycle 2.
  - Read with rvalid at cycle 2: rdata_valid at cycle 3.
- Back-to-back: a new command can be accepted in the cycle done is high (busy=0 that cycle).

Optional Feature:
- Macro: MEM_PORT_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on acceptance and increments in REQ and WAIT_R.
  - When it reaches TIMEOUT with no completion: err pulse next cycle, no done or rdata_valid, mem_req=0, return to IDLE, rdata unchanged.
  - A completion event in the same cycle the count hits TIMEOUT wins over the timeout.
- Undefined: no counter; the FSM waits indefinitely in REQ or WAIT_R.

Decomposition:
- Shared package (core_pkg):
  - op encodings MEM_OP_NONE/READ/WRITE/RSVD.
  - mem_state_t enum (IDLE, REQ, WAIT_R).
  - default DATA_W/ADDR_W constants.
- Sub-module: mem_timeout_ctr, a clearable saturating counter with a terminal-count output. Instantiated only under MEM_PORT_TIMEOUT_EN.

Test Plan:
- Write, zero-wait: cmd op=10 addr=0x0040 wdata=0xBEEF, gnt same cycle as req -> mem_we=1, mem_addr=0x0040, mem_wdata=0xBEEF, mem_id=core_id; done at cycle 2; busy cycles 0-1.
- Read, 3-cycle gnt delay and 2-cycle data delay: addr=0x0100, mem_rdata=0x1234 -> request outputs stable for all wait cycles; rdata=0x1234 with rdata_valid one cycle after rvalid; single done pulse.
- Protocol errors: op=11 in IDLE -> err pulse, no mem_req. Second cmd_valid during an in-flight read -> err pulse, first read completes normally.
- Read with gnt and rvalid in the same cycle (0x00FF) -> no WAIT_R, rdata_valid at cycle 2. Stray rvalid in IDLE -> rdata unchanged.
- Reset asserted in WAIT_R -> next cycle busy=0, mem_req=0, rdata=0, no done; a later rvalid is ignored.
- MEM_PORT_TIMEOUT_EN, TIMEOUT=8, gnt never given -> err at cycle 9 after accept, mem_req low, busy low. Rerun with gnt at count 8 -> completion, no err.
